axis_stream_arbiter: RTL and testbench
======================================

Name: axis_stream_arbiter

Overview:
- Shares one downstream AXI4-Stream consumer (e.g. a width adapter feeding a DMA/FIFO) among NUM_INPUTS slave streams of equal width.
- Round-robin arbitration. A grant is held for up to BURST_LEN beats or until the granted stream stalls.
- Output is fully registered. The source index of each beat is reported on M_AXIS_tuser.
- Sits between the per-channel signal-processing streams and the shared capture path.

Parameters:
- AXIS_TDATA_WIDTH, 32, data width of every slave and of the master stream.
- NUM_INPUTS, 2, number of slave streams; legal range 2..4.
- BURST_LEN, 16, maximum beats per grant; legal range 1..256.
- ID_WIDTH, derived = max(1, clog2(NUM_INPUTS)), not user-set; width of M_AXIS_tuser.

Ports:
- aclk  input  1  clock, all logic rising-edge.
- aresetn  input  1  asynchronous active-low reset; deassertion assumed synchronous to aclk.
- S_AXIS_tvalid  input  NUM_INPUTS  per-slave valid; bit i belongs to slave i.
- S_AXIS_tdata  input  NUM_INPUTS*AXIS_TDATA_WIDTH  slave i data in bits [i*W +: W].
- S_AXIS_tready  output  NUM_INPUTS  per-slave ready.
- M_AXIS_tready  input  1  downstream ready.
- M_AXIS_tvalid  output  1  registered valid.
- M_AXIS_tdata  output  AXIS_TDATA_WIDTH  registered data.
- M_AXIS_tuser  output  ID_WIDTH  index of the slave that supplied the current beat.

Behaviour:
- Reset (aresetn low, asynchronous):
  - state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0.
  - M_AXIS_tvalid=0, M_AXIS_tdata=0, M_AXIS_tuser=0.
  - S_AXIS_tready=0 for all slaves.
  - Reset mid-burst discards any beat held in the output register.
- Output register:
  - Single entry. can_load = !M_AXIS_tvalid || M_AXIS_tready.
  - On a slave handshake: load tdata, tuser=grant_id, set tvalid.
  - Else if M_AXIS_tready: clear tvalid.
  - tdata/tuser hold stable while tvalid && !tready. They are not cleared on drain.
  - The register drains independently of FSM state.
- S_AXIS_tready[i] = (state==GRANT) && (grant_id==i) && can_load. Purely combinational from registers and M_AXIS_tready. All other bits are 0.
- FSM state IDLE:
  - Search S_AXIS_tvalid starting at rr_ptr, ascending with wrap, for the first set bit j.
  - If found: on the next edge go to GRANT with grant_id=j and beat_cnt=0.
  - If none: stay in IDLE.
  - No slave transfers occur in IDLE.
- FSM state GRANT:
  - Each accepted beat (S_AXIS_tvalid[grant_id] && S_AXIS_tready[grant_id]) increments beat_cnt.
  - Release when the accepted beat has beat_cnt==BURST_LEN-1 (burst complete), or when can_load && !S_AXIS_tvalid[grant_id] (gap release).
  - On release: go to IDLE and set rr_ptr=(grant_id+1) mod NUM_INPUTS.
  - If can_load is 0 (downstream stall), no release and no count change, regardless of tvalid.
- Latency and throughput:
  - A request in IDLE at cycle 0 gives a grant at edge 1; the first slave handshake can occur in cycle 1 and the beat is on M_AXIS from cycle 2.
  - At least one IDLE cycle separates grants. Sustained throughput with all slaves busy is BURST_LEN/(BURST_LEN+1).
- Simultaneous events:
  - Load and drain in the same cycle is a pass-through: the register is replaced with tvalid staying 1.
  - Release and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle.
  - A slave dropping tvalid mid-packet is legal. The arbiter does not track packet boundaries and has no tlast.
- Fairness: a continuously requesting slave waits at most (NUM_INPUTS-1)*(BURST_LEN+1) cycles for a grant, excluding downstream stall cycles.

Test Plan:
1. Only slave 1 valid, tdata 0xA1, 0xA2, 0xA3 on consecutive cycles, M_AXIS_tready=1 -> grant at edge 1; M_AXIS shows 0xA1..0xA3 with tuser=1 in cycles 2..4; gap release follows; rr_ptr=0.
2. NUM_INPUTS=2, BURST_LEN=4, both slaves always valid, M_AXIS_tready=1 -> output repeats 4 beats tuser=0, one empty cycle, 4 beats tuser=1, one empty cycle; no beat lost or duplicated versus the per-slave sequence counters.
3. M_AXIS_tready low for 5 cycles during beat 2 of a burst -> M_AXIS_tdata/tuser held stable, S_AXIS_tready=0, beat_cnt frozen, no release; the burst resumes and completes at exactly 4 beats.
4. Slave 0 granted, drops tvalid after 2 beats while slave 1 is valid -> gap release, one IDLE cycle, then a grant to slave 1; slave 0's next beats are served only after slave 1's grant.
5. aresetn pulsed low mid-burst with a beat pending -> M_AXIS_tvalid/tdata/tuser and S_AXIS_tready go to 0 immediately; after release with both slaves valid, the first grant goes to slave 0.
6. NUM_INPUTS=3, BURST_LEN=1, all valid -> tuser sequence 0,1,2,0,1,2, one beat every 2 cycles.

Source files
------------

// File: rtl/axis_stream_arbiter.sv
// Round-robin AXI4-Stream arbiter: NUM_INPUTS slave streams share one registered master stream.
// A grant lasts up to BURST_LEN beats or until the granted slave stalls; tuser carries the source index.
module axis_stream_arbiter #(
    parameter  int unsigned AXIS_TDATA_WIDTH = 32,
    parameter  int unsigned NUM_INPUTS       = 2,
    parameter  int unsigned BURST_LEN        = 16,
    localparam int unsigned ID_WIDTH         = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    input  logic [NUM_INPUTS-1:0]                  S_AXIS_tvalid,
    input  logic [NUM_INPUTS*AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic [NUM_INPUTS-1:0]                  S_AXIS_tready,
    input  logic                                   M_AXIS_tready,
    output logic                                   M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0]            M_AXIS_tdata,
    output logic [ID_WIDTH-1:0]                    M_AXIS_tuser
);

    localparam int unsigned CNT_WIDTH = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [ID_WIDTH-1:0]  LAST_ID   = ID_WIDTH'(NUM_INPUTS - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

    logic [0:0]                  r_state;
    logic [ID_WIDTH-1:0]         r_rr_ptr;
    logic [CNT_WIDTH-1:0]        r_beat_cnt;
    logic [ID_WIDTH-1:0]         r_grant_id;
    logic                        r_m_tvalid;
    logic [AXIS_TDATA_WIDTH-1:0] r_m_tdata;
    logic [ID_WIDTH-1:0]         r_m_tuser;

    logic [0:0]                  w_state_nxt;
    logic [ID_WIDTH-1:0]         w_rr_ptr_nxt;
    logic [CNT_WIDTH-1:0]        w_beat_cnt_nxt;
    logic [ID_WIDTH-1:0]         w_grant_id_nxt;
    logic                        w_can_load;
    logic                        w_gnt_valid;
    logic                        w_accept;
    logic                        w_found;
    logic [ID_WIDTH-1:0]         w_pick;
    logic [ID_WIDTH-1:0]         w_next_id;
    logic [AXIS_TDATA_WIDTH-1:0] w_sel_data;

    // (base + ofs) mod NUM_INPUTS; both operands are below NUM_INPUTS so one subtraction suffices
    function automatic logic [ID_WIDTH-1:0] wrap_idx(input logic [ID_WIDTH-1:0] base,
                                                     input int unsigned        ofs);
        int unsigned sum;
        sum = 32'(base) + ofs;
        if (sum >= NUM_INPUTS) begin
            sum = sum - NUM_INPUTS;
        end
        return ID_WIDTH'(sum);
    endfunction

    assign w_can_load  = !r_m_tvalid || M_AXIS_tready;
    assign w_gnt_valid = S_AXIS_tvalid[r_grant_id];
    assign w_accept    = (r_state == ST_GRANT) && w_can_load && w_gnt_valid;
    assign w_next_id   = (r_grant_id == LAST_ID) ? '0 : r_grant_id + ID_WIDTH'(1);

    // First requesting slave at or after the round-robin pointer
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            if (!w_found && S_AXIS_tvalid[wrap_idx(r_rr_ptr, k)]) begin
                w_found = 1'b1;
                w_pick  = wrap_idx(r_rr_ptr, k);
            end
        end
    end

    always_comb begin
        w_sel_data    = '0;
        S_AXIS_tready = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (r_grant_id == ID_WIDTH'(i)) begin
                w_sel_data = S_AXIS_tdata[i*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
            end
            S_AXIS_tready[i] = (r_state == ST_GRANT) && (r_grant_id == ID_WIDTH'(i)) && w_can_load;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_grant_id <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_grant_id <= w_grant_id_nxt;
        end
    end

    // A downstream stall freezes the grant: no count change and no release
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        w_grant_id_nxt = r_grant_id;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = ST_GRANT;
                    w_grant_id_nxt = w_pick;
                    w_beat_cnt_nxt = '0;
                end
            end
            ST_GRANT: begin
                if (w_can_load) begin
                    if (!w_gnt_valid || (r_beat_cnt == LAST_BEAT)) begin
                        w_state_nxt    = ST_IDLE;
                        w_rr_ptr_nxt   = w_next_id;
                        w_beat_cnt_nxt = '0;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Single-entry output register; drains independently of the grant state
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tuser  <= '0;
        end else if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_sel_data;
            r_m_tuser  <= r_grant_id;
        end else if (M_AXIS_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign M_AXIS_tvalid = r_m_tvalid;
    assign M_AXIS_tdata  = r_m_tdata;
    assign M_AXIS_tuser  = r_m_tuser;

endmodule

// File: tb/tb_axis_stream_arbiter.sv
// Bench for axis_stream_arbiter: two instances (2 inputs/burst 4 and 3 inputs/burst 1) checked
// cycle by cycle against a transaction-level reference model, plus directed scenario checks.
module tb_axis_stream_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic [1:0]  a_tvalid, a_tready;
    logic [63:0] a_tdata;
    logic        a_mready, a_mvalid;
    logic [31:0] a_mdata;
    logic [0:0]  a_muser;

    logic [2:0]  b_tvalid, b_tready;
    logic [95:0] b_tdata;
    logic        b_mready, b_mvalid;
    logic [31:0] b_mdata;
    logic [1:0]  b_muser;

    axis_stream_arbiter #(.AXIS_TDATA_WIDTH(32), .NUM_INPUTS(2), .BURST_LEN(4)) u_dut_a (
        .aclk(clk), .aresetn(rst_n),
        .S_AXIS_tvalid(a_tvalid), .S_AXIS_tdata(a_tdata), .S_AXIS_tready(a_tready),
        .M_AXIS_tready(a_mready), .M_AXIS_tvalid(a_mvalid), .M_AXIS_tdata(a_mdata),
        .M_AXIS_tuser(a_muser)
    );

    axis_stream_arbiter #(.AXIS_TDATA_WIDTH(32), .NUM_INPUTS(3), .BURST_LEN(1)) u_dut_b (
        .aclk(clk), .aresetn(rst_n),
        .S_AXIS_tvalid(b_tvalid), .S_AXIS_tdata(b_tdata), .S_AXIS_tready(b_tready),
        .M_AXIS_tready(b_mready), .M_AXIS_tvalid(b_mvalid), .M_AXIS_tdata(b_mdata),
        .M_AXIS_tuser(b_muser)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Per-instance slave sources: beat value = base + number of beats already taken
    logic [31:0] base [2][4];
    int          seq  [2][4];

    // Reference model: owner=-1 means nobody holds the grant
    int          m_owner [2];
    int          m_cnt   [2];
    int          m_ptr   [2];
    int          m_ou    [2];
    logic        m_ov    [2];
    logic [31:0] m_od    [2];

    int   p;
    logic hit;
    logic ev;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dval(input int k, input int i);
        return base[k][i] + 32'(seq[k][i]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_cnt[k]   = 0;
            m_ptr[k]   = 0;
            m_ou[k]    = 0;
            m_ov[k]    = 1'b0;
            m_od[k]    = '0;
        end
    endtask

    function automatic logic [3:0] exp_tready(input int k, input logic mready);
        logic [3:0] r;
        r = '0;
        if (m_owner[k] >= 0 && (!m_ov[k] || mready)) r[m_owner[k]] = 1'b1;
        return r;
    endfunction

    // One clock edge of the model, from the rules: beats flow only to the current owner,
    // a grant ends after blen beats or on the first gap, and the search resumes after the owner.
    task automatic model_step(input int k, input int n, input int blen,
                              input logic [3:0] tv, input logic mready);
        logic can_load;
        logic acc;
        int   j;
        can_load = !m_ov[k] || mready;
        acc = (m_owner[k] >= 0) && can_load && tv[m_owner[k]];
        if (acc) begin
            m_od[k] = dval(k, m_owner[k]);
            m_ou[k] = m_owner[k];
            m_ov[k] = 1'b1;
            seq[k][m_owner[k]]++;
        end else if (mready) begin
            m_ov[k] = 1'b0;
        end
        if (m_owner[k] < 0) begin
            for (int s = 0; s < n; s++) begin
                j = (m_ptr[k] + s) % n;
                if (tv[j]) begin
                    m_owner[k] = j;
                    m_cnt[k]   = 0;
                    break;
                end
            end
        end else if (can_load) begin
            if (acc) m_cnt[k]++;
            if (!acc || m_cnt[k] == blen) begin
                m_ptr[k]   = (m_owner[k] + 1) % n;
                m_owner[k] = -1;
            end
        end
    endtask

    task automatic run_cycle(input logic [3:0] tv_a, input logic ma,
                             input logic [3:0] tv_b, input logic mb);
        @(negedge clk);
        a_tvalid = tv_a[1:0];
        a_mready = ma;
        for (int i = 0; i < 2; i++) a_tdata[i*32 +: 32] = dval(0, i);
        b_tvalid = tv_b[2:0];
        b_mready = mb;
        for (int i = 0; i < 3; i++) b_tdata[i*32 +: 32] = dval(1, i);
        #1;
        check($sformatf("A.s_tready@%0d", cyc), 64'(a_tready), 64'(exp_tready(0, ma)));
        check($sformatf("A.m_tvalid@%0d", cyc), 64'(a_mvalid), 64'(m_ov[0]));
        check($sformatf("A.m_tdata@%0d",  cyc), 64'(a_mdata),  64'(m_od[0]));
        check($sformatf("A.m_tuser@%0d",  cyc), 64'(a_muser),  64'(m_ou[0]));
        check($sformatf("B.s_tready@%0d", cyc), 64'(b_tready), 64'(exp_tready(1, mb)));
        check($sformatf("B.m_tvalid@%0d", cyc), 64'(b_mvalid), 64'(m_ov[1]));
        check($sformatf("B.m_tdata@%0d",  cyc), 64'(b_mdata),  64'(m_od[1]));
        check($sformatf("B.m_tuser@%0d",  cyc), 64'(b_muser),  64'(m_ou[1]));
        model_step(0, 2, 4, tv_a, ma);
        model_step(1, 3, 1, tv_b, mb);
        cyc++;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".A.m_tvalid"}, 64'(a_mvalid), 64'(0));
        check({tag, ".A.m_tdata"},  64'(a_mdata),  64'(0));
        check({tag, ".A.m_tuser"},  64'(a_muser),  64'(0));
        check({tag, ".A.s_tready"}, 64'(a_tready), 64'(0));
        check({tag, ".B.m_tvalid"}, 64'(b_mvalid), 64'(0));
        check({tag, ".B.m_tdata"},  64'(b_mdata),  64'(0));
        check({tag, ".B.m_tuser"},  64'(b_muser),  64'(0));
        check({tag, ".B.s_tready"}, 64'(b_tready), 64'(0));
    endtask

    initial begin
        rst_n    = 1'b0;
        a_tvalid = '0; a_tdata = '0; a_mready = 1'b1;
        b_tvalid = '0; b_tdata = '0; b_mready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                base[k][i] = {4'(k), 4'(i), 24'h0};
                seq[k][i]  = 0;
            end
        end
        base[0][1] = 32'h0000_00A1;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Lone slave 1 streams A1..A3, then a gap release
        for (int c = 0; c < 8; c++) begin
            run_cycle((seq[0][1] < 3) ? 4'b0010 : 4'b0000, 1'b1, 4'b0000, 1'b1);
            if (c >= 2 && c <= 4) begin
                check($sformatf("t1.tdata@%0d", c), 64'(a_mdata), 64'(32'hA1 + 32'(c - 2)));
                check($sformatf("t1.tuser@%0d", c), 64'(a_muser), 64'(1));
                check($sformatf("t1.tvalid@%0d", c), 64'(a_mvalid), 64'(1));
            end else begin
                check($sformatf("t1.tvalid@%0d", c), 64'(a_mvalid), 64'(0));
            end
        end

        // Slave 0 drops valid after two beats while slave 1 waits
        for (int c = 0; c < 12; c++) begin
            run_cycle((c == 3) ? 4'b0010 : 4'b0011, 1'b1, 4'b0000, 1'b1);
            if (c == 2 || c == 3 || c == 11) begin
                check($sformatf("t4.tvalid@%0d", c), 64'(a_mvalid), 64'(1));
                check($sformatf("t4.tuser@%0d", c), 64'(a_muser), 64'(0));
            end else if (c >= 6 && c <= 9) begin
                check($sformatf("t4.tvalid@%0d", c), 64'(a_mvalid), 64'(1));
                check($sformatf("t4.tuser@%0d", c), 64'(a_muser), 64'(1));
            end else if (c == 4 || c == 5 || c == 10) begin
                check($sformatf("t4.tvalid@%0d", c), 64'(a_mvalid), 64'(0));
            end
        end

        // Downstream stall for 5 cycles during beat 2 of a burst
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            run_cycle(4'b0011, 1'b1, 4'b0000, 1'b1);
            hit = (m_owner[0] >= 0) && (m_cnt[0] == 1);
        end
        check("t3.reach_beat2", 64'(hit), 64'(1));
        for (int c = 0; c < 5; c++) begin
            run_cycle(4'b0011, 1'b0, 4'b0000, 1'b1);
            check($sformatf("t3.s_tready@%0d", c), 64'(a_tready), 64'(0));
            check($sformatf("t3.tvalid@%0d", c), 64'(a_mvalid), 64'(1));
        end
        for (int c = 0; c < 12; c++) run_cycle(4'b0011, 1'b1, 4'b0000, 1'b1);

        // Asynchronous reset with beats pending in both output registers
        for (int c = 0; c < 3; c++) run_cycle(4'b0011, 1'b0, 4'b0111, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("t5");
        model_reset();
        a_tvalid = '0;
        b_tvalid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // All slaves busy: 4+gap pattern on A, one beat every 2 cycles rotating on B
        for (int c = 0; c < 30; c++) begin
            run_cycle(4'b0011, 1'b1, 4'b0111, 1'b1);
            p  = (c >= 2) ? (c - 2) % 10 : 4;
            ev = (p != 4) && (p != 9);
            check($sformatf("t2.tvalid@%0d", c), 64'(a_mvalid), 64'(ev));
            if (ev) check($sformatf("t2.tuser@%0d", c), 64'(a_muser), 64'((p < 4) ? 0 : 1));
            ev = (c >= 2) && (c % 2 == 0);
            check($sformatf("t6.tvalid@%0d", c), 64'(b_mvalid), 64'(ev));
            if (ev) check($sformatf("t6.tuser@%0d", c), 64'(b_muser), 64'(((c - 2) / 2) % 3));
        end

        // Random traffic and back-pressure against the model
        for (int c = 0; c < 600; c++) begin
            run_cycle(4'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                      4'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
